// File: rtl/dac_pkg.sv
// Definitions shared by the 1-bit DAC modulator and its bitstream decoder.
package dac_pkg;

    localparam int RES_DEFAULT = 7;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    function automatic int win_len(input int res);
        return 2 ** (res + 1);
    endfunction

    localparam int WIN_LEN = win_len(RES_DEFAULT);

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser bringing the asynchronous bitstream into the clk domain.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/sd_bitstream_decoder.sv
// Recovers an (RES+1)-bit sample from a 1-bit density stream by counting ones
// over a fixed window, and presents it on a valid/ready port with overrun flag.
module sd_bitstream_decoder
    import dac_pkg::*;
#(
    parameter int RES = RES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_in,
    input  logic         en,
    output logic [RES:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    input  logic         overrun_clr,
    output logic         overrun
);

    localparam logic [RES:0] WIN_LAST = (RES + 1)'(win_len(RES) - 1);

    logic           bit_s;
    logic [RES:0]   win_cnt;
    logic [RES+1:0] acc;
    logic [RES+1:0] total;
    logic           terminal;
    out_state_e     state;
    out_state_e     state_next;
    logic           overrun_set;

    // A full window of ones counts to 2^(RES+1), one past the sample range.
    function automatic logic [RES:0] saturate(input logic [RES+1:0] value);
        return value[RES+1] ? '1 : value[RES:0];
    endfunction

    bit_sync u_bit_sync (
        .clk (clk),
        .rst (rst),
        .d   (bit_in),
        .q   (bit_s)
    );

    assign total    = acc + (RES + 2)'(bit_s);
    assign terminal = en && (win_cnt == WIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            acc     <= '0;
            dout    <= '0;
            state   <= EMPTY;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            overrun <= overrun_set | (overrun & ~overrun_clr);
            if (en) begin
                win_cnt <= win_cnt + (RES + 1)'(1);
                if (terminal) begin
                    acc  <= '0;
                    dout <= saturate(total);
                end else begin
                    acc  <= total;
                end
            end
        end
    end

    always_comb begin
        state_next  = state;
        overrun_set = 1'b0;
        case (state)
            EMPTY: begin
                if (terminal) state_next = FULL;
            end
            FULL: begin
                // A terminal edge keeps FULL; without an accept it overwrites.
                if (terminal) begin
                    state_next  = FULL;
                    overrun_set = ~dout_ready;
                end else if (dout_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    assign dout_valid = (state == FULL);

endmodule

// File: tb/tb_sd_bitstream_decoder.sv
// Randomised and directed bench for sd_bitstream_decoder with a window-level model.
module tb_sd_bitstream_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       en = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic       overrun;

    logic [3:0] dout3;
    logic       valid3;
    logic       ovr3;

    int checks = 0;
    int errors = 0;

    sd_bitstream_decoder #(.RES(7)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .en(en),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overrun_clr(overrun_clr), .overrun(overrun)
    );

    sd_bitstream_decoder #(.RES(3)) dut3 (
        .clk(clk), .rst(rst), .bit_in(1'b1), .en(1'b1),
        .dout(dout3), .dout_valid(valid3), .dout_ready(1'b1),
        .overrun_clr(1'b0), .overrun(ovr3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each enabled edge adds the bit_in value seen two edges earlier;
    // every 256 enabled edges the ones count (capped at 255) becomes a sample.
    int m_dout, m_ones, m_cnt;
    bit m_valid, m_ovr;
    bit hist[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dout = 0; m_ones = 0; m_cnt = 0; m_valid = 0; m_ovr = 0;
            hist = '{1'b0, 1'b0};
        end else begin
            bit bs, set_ovr;
            bs = hist.pop_front();
            hist.push_back(bit_in);
            set_ovr = 0;
            if (en) begin
                m_ones += int'(bs);
                m_cnt++;
            end
            if (en && m_cnt == 256) begin
                m_dout = (m_ones > 255) ? 255 : m_ones;
                if (m_valid && !dout_ready) set_ovr = 1;
                m_valid = 1;
                m_ones = 0;
                m_cnt = 0;
            end else if (m_valid && dout_ready) begin
                m_valid = 0;
            end
            if (set_ovr) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("dout", int'(dout), m_dout);
            chk("dout_valid", int'(dout_valid), int'(m_valid));
            chk("overrun", int'(overrun), int'(m_ovr));
        end
    end

    // RES=3 instance fed constant ones: 0xE in the first window, 0xF after.
    bit first3 = 1;
    always @(negedge clk) begin
        if (rst) first3 = 1;
        else if (valid3) begin
            chk("res3_dout", int'(dout3), first3 ? 14 : 15);
            first3 = 0;
        end
    end

    int mode = 0;
    bit alt = 1;
    int pcnt = 0;

    task automatic cycle();
        case (mode)
            0: bit_in = 1'b0;
            1: bit_in = 1'b1;
            2: begin bit_in = alt; alt = ~alt; end
            3: bit_in = 1'($urandom % 2);
            default: begin bit_in = (pcnt == 0); pcnt = (pcnt + 1) % 256; end
        endcase
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output int k);
        k = 0;
        do begin
            cycle();
            k++;
        end while (!dout_valid && k < maxc);
        if (!dout_valid) begin
            errors++;
            $display("FAIL wait_valid: no dout_valid within %0d cycles", maxc);
        end
    endtask

    initial begin
        int k;
        en = 1'b0; dout_ready = 1'b0; mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_dout", int'(dout), 0);
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_overrun", int'(overrun), 0);

        // Constant zero with consumer ready.
        en = 1'b1; dout_ready = 1'b1; mode = 0;
        #1 rst = 1'b0;
        wait_valid(300, k);
        chk("first_valid_latency", k, 256);
        chk("zero_win1", int'(dout), 0);
        wait_valid(300, k);
        chk("valid_period", k, 256);
        chk("zero_win2", int'(dout), 0);
        cycle();
        chk("valid_one_cycle", int'(dout_valid), 0);

        // Constant one.
        mode = 1;
        reset_dut();
        wait_valid(300, k);
        chk("ones_win1", int'(dout), 8'hFE);
        wait_valid(300, k);
        chk("ones_win2", int'(dout), 8'hFF);
        wait_valid(300, k);
        chk("ones_win3", int'(dout), 8'hFF);

        // Alternating, phase-aligned to the window.
        mode = 2; alt = 1;
        reset_dut();
        wait_valid(300, k);
        chk("alt_win1", int'(dout), 8'h7F);
        wait_valid(300, k);
        chk("alt_win2", int'(dout), 8'h80);

        // One pulse per 256 clocks.
        mode = 4; pcnt = 0;
        reset_dut();
        wait_valid(300, k);
        wait_valid(300, k);
        chk("pulse_win2", int'(dout), 8'h01);
        wait_valid(300, k);
        chk("pulse_win3", int'(dout), 8'h01);

        // Overrun: ready low across two terminal edges.
        mode = 0; dout_ready = 1'b0;
        reset_dut();
        repeat (254) cycle();
        mode = 2; alt = 1;
        wait_valid(10, k);
        chk("ovr_first_latency", k, 2);
        chk("ovr_first_dout", int'(dout), 0);
        k = 0;
        while (!overrun && k < 300) begin cycle(); k++; end
        chk("ovr_set_latency", k, 256);
        chk("ovr_dout", int'(dout), 8'h80);
        chk("ovr_valid", int'(dout_valid), 1);
        overrun_clr = 1'b1; cycle(); overrun_clr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);
        dout_ready = 1'b1; cycle(); dout_ready = 1'b0;
        chk("ovr_accepted", int'(dout_valid), 0);

        // Asynchronous reset mid-window.
        mode = 3;
        reset_dut();
        repeat (356) cycle();
        chk("pre_reset_valid", int'(dout_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_dout", int'(dout), 0);
        chk("async_valid", int'(dout_valid), 0);
        chk("async_overrun", int'(overrun), 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        dout_ready = 1'b1;
        wait_valid(300, k);
        chk("post_reset_latency", k, 256);

        // Enable gap of 50 cycles delays the sample by exactly 50.
        reset_dut();
        repeat (100) cycle();
        en = 1'b0;
        repeat (50) cycle();
        en = 1'b1;
        wait_valid(400, k);
        chk("en_gap_latency", 150 + k, 306);

        // Random enable, ready and clear.
        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom % 10) != 0;
            dout_ready = ($urandom % 4) == 0;
            overrun_clr = ($urandom % 32) == 0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
